// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request,
// one-entry hand-off register to decode, branch redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rs,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        misalign,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc4_d;
  logic        mis_d;
  logic [15:0] cnt_d;

  assign imem_req  = en & (state_q == FETCH);
  assign imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = id_valid;
    instr_d = id_instr;
    pc4_d   = id_pc4;
    cnt_d   = fetch_count;
    mis_d   = en ? 1'b0 : misalign;
    if (en) begin
      // a redirect wins over ack and id_ready in the same cycle
      if (branch_taken) begin
        pc_d    = {branch_target[31:2], 2'b00};
        valid_d = 1'b0;
        state_d = FETCH;
        mis_d   = |branch_target[1:0];
      end else begin
        unique case (state_q)
          FETCH: begin
            if (imem_ack) begin
              instr_d = imem_rdata;
              pc4_d   = pc_q + 32'd4;
              pc_d    = pc_q + 32'd4;
              valid_d = 1'b1;
              cnt_d   = fetch_count + 16'd1;
              state_d = HOLD;
            end
          end
          HOLD: begin
            if (id_ready) begin
              valid_d = 1'b0;
              state_d = FETCH;
            end
          end
          default: state_d = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc4      <= 32'h0;
      misalign    <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_valid    <= valid_d;
      id_instr    <= instr_d;
      id_pc4      <= pc4_d;
      misalign    <= mis_d;
      fetch_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rs = 1'b0;
  logic        en = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        id_ready = 1'b0;

  logic        imem_req, id_valid, misalign;
  logic [31:0] imem_addr, id_instr, id_pc4;
  logic [15:0] fetch_count;

  logic        imem_req2, id_valid2, misalign2;
  logic [31:0] imem_addr2, id_instr2, id_pc42;
  logic [15:0] fetch_count2;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: "holding" means an instruction sits in the id_* register
  logic [31:0] m_pc = 32'h0;
  logic        m_hold = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc4 = 32'h0;
  logic        m_mis = 1'b0;
  logic [15:0] m_cnt = 16'h0;
  logic [31:0] snap;

  fetch_stage dut (
    .clk(clk), .rs(rs), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc4(id_pc4),
    .misalign(misalign), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rs(rs), .en(en),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ready(id_ready), .id_valid(id_valid2),
    .id_instr(id_instr2), .id_pc4(id_pc42),
    .misalign(misalign2), .fetch_count(fetch_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rs) begin
      m_pc = 32'h0; m_hold = 1'b0; m_instr = 32'h0;
      m_pc4 = 32'h0; m_mis = 1'b0; m_cnt = 16'h0;
    end else if (en) begin
      m_mis = 1'b0;
      if (branch_taken) begin
        m_pc   = branch_target & 32'hFFFF_FFFC;
        m_hold = 1'b0;
        m_mis  = (branch_target % 4) != 0;
      end else if (!m_hold && imem_ack) begin
        m_instr = imem_rdata;
        m_pc4   = m_pc + 4;
        m_pc    = m_pc + 4;
        m_hold  = 1'b1;
        m_cnt   = m_cnt + 1;
      end else if (m_hold && id_ready) begin
        m_hold = 1'b0;
      end
    end
  endtask

  // check everything against the model, then clock once
  task automatic cyc();
    #1;
    chk("imem_req", 32'(imem_req), 32'(en && !m_hold));
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_hold));
    chk("id_instr", id_instr, m_instr);
    chk("id_pc4", id_pc4, m_pc4);
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset, then ack on the third request cycle
    rs = 1'b1; en = 1'b1; cyc();
    rs = 1'b0;
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_count", 32'(fetch_count), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    cyc();
    cyc();
    chk("addr_held", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h8C22_0004; cyc();
    imem_ack = 1'b0;
    chk("d_valid", 32'(id_valid), 32'h1);
    chk("d_instr", id_instr, 32'h8C22_0004);
    chk("d_pc4", id_pc4, 32'h4);
    chk("d_count", 32'(fetch_count), 32'h1);

    // decode stalls for 4 cycles
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_instr", id_instr, 32'h8C22_0004);
      chk("stall_req", 32'(imem_req), 32'h0);
    end
    id_ready = 1'b1; cyc();
    id_ready = 1'b0;
    chk("rel_valid", 32'(id_valid), 32'h0);
    chk("rel_addr", imem_addr, 32'h4);

    // branch coincident with ack, misaligned target
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    branch_taken = 1'b1; branch_target = 32'h0000_0102; cyc();
    imem_ack = 1'b0; branch_taken = 1'b0;
    chk("br_mis", 32'(misalign), 32'h1);
    chk("br_addr", imem_addr, 32'h0000_0100);
    chk("br_count", 32'(fetch_count), 32'h1);
    chk("br_valid", 32'(id_valid), 32'h0);
    cyc();
    chk("mis_pulse", 32'(misalign), 32'h0);

    // en drops while a request at pc=8 is pending
    branch_taken = 1'b1; branch_target = 32'h8; cyc();
    branch_taken = 1'b0;
    en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("en0_req", 32'(imem_req), 32'h0);
      cyc();
    end
    chk("en0_valid", 32'(id_valid), 32'h0);
    imem_ack = 1'b0; en = 1'b1;
    #1;
    chk("en1_req", 32'(imem_req), 32'h1);
    chk("en1_addr", imem_addr, 32'h8);
    cyc();

    // reset while an instruction is held
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; cyc();
    imem_ack = 1'b0; id_ready = 1'b0; cyc();
    chk("pre_valid", 32'(id_valid), 32'h1);
    rs = 1'b1; cyc();
    rs = 1'b0;
    chk("mr_valid", 32'(id_valid), 32'h0);
    chk("mr_count", 32'(fetch_count), 32'h0);
    chk("mr_addr", imem_addr, 32'h0);

    // PC wrap on the high-reset instance
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D; cyc();
    imem_ack = 1'b0;
    chk("wrap_valid", 32'(id_valid2), 32'h1);
    chk("wrap_pc4", id_pc42, 32'h0);
    id_ready = 1'b1; cyc();
    id_ready = 1'b0;
    chk("wrap_addr", imem_addr2, 32'h0);
    chk("wrap_req", 32'(imem_req2), 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rs            = ($urandom_range(0, 49) == 0);
      en            = ($urandom_range(0, 9) != 0);
      imem_ack      = $urandom_range(0, 1) == 1;
      imem_rdata    = $urandom;
      branch_taken  = ($urandom_range(0, 6) == 0);
      branch_target = $urandom;
      id_ready      = $urandom_range(0, 1) == 1;
      cyc();
    end
    rs = 1'b0; en = 1'b1; branch_taken = 1'b0;
    imem_ack = 1'b0; id_ready = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
